data_mem_arbiter: RTL and testbench
===================================

// Module: data_mem_arbiter
// PURPOSE
//  Shares one synchronous data RAM between two bus masters (m0 = CPU load/store port, m1 = DMA/IO master).
//  Arbitrates round-robin, decodes the 32-bit address against the RAM window and sequences one access at a time.
//  Window hit: drives the RAM for one cycle, waits RD_LAT cycles on reads, then returns data.
//  Window miss: RAM untouched, error response returned.
// PARAMETERS
//  ADDR_BASE  32'h0000_2300  base of RAM window
//  ADDR_MASK  32'hFFFF_FF00  hit when (addr & ADDR_MASK) == ADDR_BASE
//  MEM_AW     8              RAM address width; mem_addr = addr[MEM_AW-1:0]
//  RD_LAT     1              RAM read latency in cycles (legal range 1..15)
// PORTS
//  clk        in   1   clock, all logic on rising edge
//  rst        in   1   synchronous reset, active-high
//  m0_req     in   1   m0 request; held high until m0_ack
//  m0_we      in   1   m0 write (1) / read (0)
//  m0_addr    in   32  m0 byte address
//  m0_wdata   in   32  m0 write data
//  m0_ack     out  1   m0 transaction done, 1-cycle pulse
//  m0_err     out  1   valid with m0_ack: address outside window
//  m0_rdata   out  32  m0 read data, valid with m0_ack
//  m1_*       same as m0_* for master 1
//  mem_cs     out  1   RAM select, 1-cycle pulse per access
//  mem_we     out  1   RAM write enable, qualified by mem_cs
//  mem_addr   out  MEM_AW  RAM word address
//  mem_wdata  out  32  RAM write data
//  mem_rdata  in   32  RAM read data, valid RD_LAT cycles after mem_cs
//  err_count  out  8   saturating count of out-of-window transactions
// BEHAVIOUR
//  Reset: state=IDLE; mx_ack/mx_err/mem_cs/mem_we=0; mx_rdata, mem_addr, mem_wdata, err_count=0; last_grant=m1.
//  FSM: IDLE -> ACCESS | RESP; ACCESS -> WAIT (read) | RESP (write); WAIT -> RESP; RESP -> IDLE.
//  IDLE: at the edge, when any req is high, pick winner; latch we/addr/wdata and winner id.
//   - one req: that master wins.
//   - both: master != last_grant wins (first contention after reset: m0); last_grant <= winner.
//   - hit -> ACCESS; miss -> RESP with err flag set, err_count+1 (saturates at 8'hFF).
//  ACCESS (1 cycle): mem_cs=1; mem_we=latched we; mem_addr=addr[MEM_AW-1:0]; mem_wdata=latched wdata.
//  WAIT: exactly RD_LAT cycles; mem_rdata captured into the winner's rdata reg at the last WAIT edge.
//  RESP (1 cycle): winner's ack=1, err=flag; rdata=captured data (reads), 32'h0 on writes and misses.
//  Loser's ack/err are 0; winner's rdata holds until its next ack.
//  Master drops req on the edge it samples ack; req high in IDLE is always a new transaction.
//  Latency from sampling edge to ack: read hit 2+RD_LAT cycles; write hit 2; miss 1.
//  Request changes after the grant edge are ignored until the next IDLE.
//  Non-winning requests wait; no request is dropped; max wait = one full transaction of the other master.
//  mem_cs is never asserted on a miss or outside ACCESS.
//  Reset in any state aborts the transaction: no ack issued; all reset values apply next cycle.
// TESTING
//  1 rst 2 cycles, idle reqs -> all outputs 0; err_count=0; mem_cs never pulses.
//  2 m0 write 32'hDEAD_BEEF @0x2305 -> mem_cs pulse, mem_we=1, mem_addr=8'h05; m0_ack 2 cycles after grant; err=0.
//  3 m0 read @0x2305, RD_LAT=1, RAM model returns stored word -> m0_rdata=32'hDEAD_BEEF, ack 3 cycles after grant.
//  4 m1 read @0x2701 -> no mem_cs; m1_ack+m1_err 1 cycle after grant; m1_rdata=0; err_count=1.
//  5 m0,m1 both held requesting 4 transactions -> grant order m0,m1,m0,m1; no double ack.
//  6 assert rst during WAIT of m1 read -> no m1_ack; IDLE next cycle; subsequent m1 read @0x2370 completes normally.

Source files
------------

// File: rtl/data_mem_arbiter.sv
// Round-robin arbiter that shares one synchronous data RAM between two bus masters.
// Hits in the RAM window are sequenced one at a time; misses return an error response.
module data_mem_arbiter #(
  parameter logic [31:0] ADDR_BASE = 32'h0000_2300,
  parameter logic [31:0] ADDR_MASK = 32'hFFFF_FF00,
  parameter int unsigned MEM_AW    = 8,
  parameter int unsigned RD_LAT    = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [31:0]       m0_addr,
  input  logic [31:0]       m0_wdata,
  output logic              m0_ack,
  output logic              m0_err,
  output logic [31:0]       m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [31:0]       m1_addr,
  input  logic [31:0]       m1_wdata,
  output logic              m1_ack,
  output logic              m1_err,
  output logic [31:0]       m1_rdata,
  output logic              mem_cs,
  output logic              mem_we,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  output logic [7:0]        err_count,
  output logic [1:0]        dbg_state
);

  // Handshake: a master raises req with we/addr/wdata stable and holds it until it
  // samples ack (one-cycle pulse; err and rdata valid with it), then drops or
  // replaces the request on that same edge. req seen high in IDLE is always new.

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_WAIT   = 2'd2,
    ST_RESP   = 2'd3
  } state_e;

  localparam logic [3:0] CNT_INIT = 4'(RD_LAT - 1);

  state_e              state_q, state_d;
  logic                sel_q, sel_d;
  logic                last_q, last_d;
  logic                we_q, we_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [7:0]          err_cnt_q, err_cnt_d;
  logic                m0_ack_q, m0_ack_d, m0_err_q, m0_err_d;
  logic [31:0]         m0_rdata_q, m0_rdata_d;
  logic                m1_ack_q, m1_ack_d, m1_err_q, m1_err_d;
  logic [31:0]         m1_rdata_q, m1_rdata_d;
  logic                mem_cs_q, mem_cs_d, mem_we_q, mem_we_d;
  logic [MEM_AW-1:0]   mem_addr_q, mem_addr_d;
  logic [31:0]         mem_wdata_q, mem_wdata_d;

  logic                win;
  logic                req_we;
  logic [31:0]         req_addr, req_wdata;
  logic                hit;
  logic                resp_fire, resp_err, resp_sel;
  logic [31:0]         resp_data;

  // last_q = 1 means m1 was granted last, so m0 wins the next contention.
  always_comb begin
    win       = m1_req && (!m0_req || !last_q);
    req_we    = win ? m1_we    : m0_we;
    req_addr  = win ? m1_addr  : m0_addr;
    req_wdata = win ? m1_wdata : m0_wdata;
    hit       = (req_addr & ADDR_MASK) == ADDR_BASE;
  end

  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    last_d      = last_q;
    we_d        = we_q;
    cnt_d       = cnt_q;
    err_cnt_d   = err_cnt_q;
    m0_ack_d    = 1'b0;
    m0_err_d    = 1'b0;
    m0_rdata_d  = m0_rdata_q;
    m1_ack_d    = 1'b0;
    m1_err_d    = 1'b0;
    m1_rdata_d  = m1_rdata_q;
    mem_cs_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    resp_fire   = 1'b0;
    resp_err    = 1'b0;
    resp_data   = 32'h0;

    case (state_q)
      ST_IDLE: begin
        if (m0_req || m1_req) begin
          sel_d  = win;
          last_d = win;
          we_d   = req_we;
          if (hit) begin
            state_d     = ST_ACCESS;
            mem_cs_d    = 1'b1;
            mem_we_d    = req_we;
            mem_addr_d  = req_addr[MEM_AW-1:0];
            mem_wdata_d = req_wdata;
          end else begin
            state_d   = ST_RESP;
            resp_fire = 1'b1;
            resp_err  = 1'b1;
            if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
          end
        end
      end
      ST_ACCESS: begin
        if (we_q) begin
          state_d   = ST_RESP;
          resp_fire = 1'b1;
        end else begin
          state_d = ST_WAIT;
          cnt_d   = CNT_INIT;
        end
      end
      ST_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d   = ST_RESP;
          resp_fire = 1'b1;
          resp_data = mem_rdata;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // A miss responds straight from IDLE, before sel_q has been updated.
    resp_sel = (state_q == ST_IDLE) ? win : sel_q;
    if (resp_fire) begin
      if (resp_sel) begin
        m1_ack_d   = 1'b1;
        m1_err_d   = resp_err;
        m1_rdata_d = resp_data;
      end else begin
        m0_ack_d   = 1'b1;
        m0_err_d   = resp_err;
        m0_rdata_d = resp_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      sel_q       <= 1'b0;
      last_q      <= 1'b1;
      we_q        <= 1'b0;
      cnt_q       <= 4'd0;
      err_cnt_q   <= 8'd0;
      m0_ack_q    <= 1'b0;
      m0_err_q    <= 1'b0;
      m0_rdata_q  <= 32'h0;
      m1_ack_q    <= 1'b0;
      m1_err_q    <= 1'b0;
      m1_rdata_q  <= 32'h0;
      mem_cs_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= 32'h0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      last_q      <= last_d;
      we_q        <= we_d;
      cnt_q       <= cnt_d;
      err_cnt_q   <= err_cnt_d;
      m0_ack_q    <= m0_ack_d;
      m0_err_q    <= m0_err_d;
      m0_rdata_q  <= m0_rdata_d;
      m1_ack_q    <= m1_ack_d;
      m1_err_q    <= m1_err_d;
      m1_rdata_q  <= m1_rdata_d;
      mem_cs_q    <= mem_cs_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign m0_ack    = m0_ack_q;
  assign m0_err    = m0_err_q;
  assign m0_rdata  = m0_rdata_q;
  assign m1_ack    = m1_ack_q;
  assign m1_err    = m1_err_q;
  assign m1_rdata  = m1_rdata_q;
  assign mem_cs    = mem_cs_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign err_count = err_cnt_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Bench for data_mem_arbiter: transaction-level latency/arbitration model checked every cycle,
// plus directed transactions with hand-computed results.
`timescale 1ns/1ps
module tb_data_mem_arbiter;

  localparam int RD_LAT = 1;
  localparam int NCYC   = 2048;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic        m0_ack, m0_err, m1_ack, m1_err;
  logic [31:0] m0_rdata, m1_rdata;
  logic        mem_cs, mem_we;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata, mem_rdata;
  logic [7:0]  err_count;
  logic [1:0]  dbg_state;

  data_mem_arbiter #(.RD_LAT(RD_LAT)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_ack(m0_ack), .m0_err(m0_err), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_ack(m1_ack), .m1_err(m1_err), .m1_rdata(m1_rdata),
    .mem_cs(mem_cs), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .err_count(err_count), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- RAM device (one cycle read latency) ----------------
  logic [31:0] ram [256];
  always @(posedge clk) begin
    if (mem_cs) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        mem_rdata     <= ram[mem_addr];
    end
  end

  // ---------------- check bookkeeping ----------------
  int n_checks = 0;
  int n_err    = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, expv, cyc);
    end
  endfunction

  // ---------------- behavioural model ----------------
  typedef struct {
    bit        cs;
    bit        we;
    bit [7:0]  addr;
    bit [31:0] wdata;
    bit        ack0;
    bit        ack1;
    bit        err;
    bit [31:0] rdata;
  } exp_t;

  exp_t        exp_a [NCYC];
  bit   [31:0] shadow [256];
  logic [31:0] exp_q [$];
  bit          started = 1'b0;
  int          free_at = 0;
  bit          m_last  = 1'b1;
  int          m_errcnt = 0;
  logic [31:0] mr0 = 32'h0;
  logic [31:0] mr1 = 32'h0;

  // Decides grants from the sampled requests using transaction latencies only.
  always @(posedge clk) begin : model_b
    int        g, lat;
    bit        w, we, hit;
    bit [31:0] a, d;
    g = cyc + 1;
    if (rst) begin
      started  = 1'b1;
      free_at  = g + 1;
      m_last   = 1'b1;
      m_errcnt = 0;
      mr0      = 32'h0;
      mr1      = 32'h0;
      exp_q.delete();
      for (int i = g; i < NCYC; i++) exp_a[i] = '{default: 0};
    end else if (started && g >= free_at && (m0_req || m1_req)) begin
      if (m0_req && m1_req) w = ~m_last;
      else                  w = m1_req;
      m_last = w;
      we  = w ? m1_we    : m0_we;
      a   = w ? m1_addr  : m0_addr;
      d   = w ? m1_wdata : m0_wdata;
      hit = (a >= 32'h0000_2300) && (a <= 32'h0000_23FF);
      lat = !hit ? 1 : (we ? 2 : 2 + RD_LAT);
      if (hit) begin
        exp_a[g].cs    = 1'b1;
        exp_a[g].we    = we;
        exp_a[g].addr  = a[7:0];
        exp_a[g].wdata = d;
      end else if (m_errcnt < 255) begin
        m_errcnt++;
      end
      if (w) exp_a[g+lat-1].ack1 = 1'b1;
      else   exp_a[g+lat-1].ack0 = 1'b1;
      exp_a[g+lat-1].err   = !hit;
      exp_a[g+lat-1].rdata = (hit && !we) ? shadow[a[7:0]] : 32'h0;
      if (hit && we) shadow[a[7:0]] = d;
      exp_q.push_back(32'(w));
      free_at = g + lat + 1;
    end
  end

  // ---------------- compare + monitor (opposite edge) ----------------
  bit          ack0_seen = 1'b0, ack1_seen = 1'b0;
  int          ack_total = 0, ack1_count = 0, cs_count = 0, double_ack = 0;
  int          ack0_cyc = 0, ack1_cyc = 0;
  logic        ack0_err, ack1_err, cs_we;
  logic [31:0] ack0_rd, ack1_rd, cs_wdata;
  logic [7:0]  cs_addr;
  int          ack_log [$];

  always @(negedge clk) begin : cmp_b
    exp_t e;
    ack0_seen = m0_ack;
    ack1_seen = m1_ack;
    if (started && cyc < NCYC) begin
      e = exp_a[cyc];
      if (e.ack0) mr0 = e.rdata;
      if (e.ack1) mr1 = e.rdata;
      chk("m0_ack",    32'(m0_ack),    32'(e.ack0));
      chk("m0_err",    32'(m0_err),    32'(e.ack0 & e.err));
      chk("m1_ack",    32'(m1_ack),    32'(e.ack1));
      chk("m1_err",    32'(m1_err),    32'(e.ack1 & e.err));
      chk("m0_rdata",  m0_rdata,       mr0);
      chk("m1_rdata",  m1_rdata,       mr1);
      chk("mem_cs",    32'(mem_cs),    32'(e.cs));
      chk("mem_we",    32'(mem_we),    32'(e.cs & e.we));
      if (e.cs) begin
        chk("mem_addr",  32'(mem_addr), 32'(e.addr));
        chk("mem_wdata", mem_wdata,     e.wdata);
      end
      chk("err_count", 32'(err_count), 32'(m_errcnt));
    end
    if (m0_ack && m1_ack) double_ack++;
    if (m0_ack) begin
      chk("sb_pending", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) chk("sb_master", 32'd0, exp_q.pop_front());
      ack_total++; ack_log.push_back(0);
      ack0_cyc = cyc; ack0_err = m0_err; ack0_rd = m0_rdata;
    end
    if (m1_ack) begin
      chk("sb_pending", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) chk("sb_master", 32'd1, exp_q.pop_front());
      ack_total++; ack1_count++; ack_log.push_back(1);
      ack1_cyc = cyc; ack1_err = m1_err; ack1_rd = m1_rdata;
    end
    if (mem_cs) begin
      cs_count++; cs_we = mem_we; cs_addr = mem_addr; cs_wdata = mem_wdata;
    end
  end

  // ---------------- master drivers ----------------
  typedef struct {
    bit        we;
    bit [31:0] addr;
    bit [31:0] wdata;
  } txn_t;

  txn_t q0 [$];
  txn_t q1 [$];
  int   raise0 = 0, raise1 = 0;

  initial begin
    m0_req = 1'b0; m0_we = 1'b0; m0_addr = 32'h0; m0_wdata = 32'h0;
    forever begin
      @(posedge clk); #1;
      if (m0_req && ack0_seen) begin
        m0_req = 1'b0;
        if (q0.size() > 0) void'(q0.pop_front());
      end
      if (!m0_req && q0.size() > 0) begin
        m0_req = 1'b1; m0_we = q0[0].we; m0_addr = q0[0].addr; m0_wdata = q0[0].wdata;
        raise0 = cyc;
      end
    end
  end

  initial begin
    m1_req = 1'b0; m1_we = 1'b0; m1_addr = 32'h0; m1_wdata = 32'h0;
    forever begin
      @(posedge clk); #1;
      if (m1_req && ack1_seen) begin
        m1_req = 1'b0;
        if (q1.size() > 0) void'(q1.pop_front());
      end
      if (!m1_req && q1.size() > 0) begin
        m1_req = 1'b1; m1_we = q1[0].we; m1_addr = q1[0].addr; m1_wdata = q1[0].wdata;
        raise1 = cyc;
      end
    end
  end

  // ---------------- directed transactions ----------------
  int          res_lat, res_cs;
  logic        res_err;
  logic [31:0] res_rd;

  task automatic run_one(input bit m, input bit we, input logic [31:0] a, input logic [31:0] d);
    txn_t t;
    int   n0, c0;
    t  = '{we: we, addr: a, wdata: d};
    n0 = ack_total;
    c0 = cs_count;
    @(negedge clk); #1;
    if (m) q1.push_back(t);
    else   q0.push_back(t);
    for (int i = 0; i < 50 && ack_total == n0; i++) begin
      @(negedge clk); #1;
    end
    chk("ack_arrived", 32'(ack_total - n0), 32'd1);
    res_cs  = cs_count - c0;
    res_lat = m ? ack1_cyc - raise1 : ack0_cyc - raise0;
    res_err = m ? ack1_err : ack0_err;
    res_rd  = m ? ack1_rd  : ack0_rd;
  endtask

  initial begin : main_b
    int base, n1;
    rst = 1'b1;
    mem_rdata <= 32'h0;
    for (int i = 0; i < 256; i++) begin
      ram[i]    <= 32'hA5A5_0000 | 32'(i);
      shadow[i]  = 32'hA5A5_0000 | 32'(i);
    end

    // 1: reset, idle requests
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk); #1;
    chk("rst_state",     32'(dbg_state), 32'd0);
    chk("rst_m0_ack",    32'(m0_ack),    32'd0);
    chk("rst_m1_err",    32'(m1_err),    32'd0);
    chk("rst_m0_rdata",  m0_rdata,       32'h0);
    chk("rst_mem_cs",    32'(mem_cs),    32'd0);
    chk("rst_err_count", 32'(err_count), 32'd0);
    repeat (5) @(negedge clk);
    chk("idle_no_cs",    32'(cs_count),  32'd0);

    // 2: m0 write hit
    run_one(1'b0, 1'b1, 32'h0000_2305, 32'hDEAD_BEEF);
    chk("wr_latency", 32'(res_lat), 32'd2);
    chk("wr_err",     32'(res_err), 32'd0);
    chk("wr_cs_cnt",  32'(res_cs),  32'd1);
    chk("wr_cs_we",   32'(cs_we),   32'd1);
    chk("wr_cs_addr", 32'(cs_addr), 32'h05);
    chk("wr_cs_data", cs_wdata,     32'hDEAD_BEEF);

    // 3: m0 read hit returns the stored word
    run_one(1'b0, 1'b0, 32'h0000_2305, 32'h0);
    chk("rd_latency", 32'(res_lat), 32'd3);
    chk("rd_err",     32'(res_err), 32'd0);
    chk("rd_data",    res_rd,       32'hDEAD_BEEF);

    // 4: m1 read miss
    run_one(1'b1, 1'b0, 32'h0000_2701, 32'h0);
    chk("miss_latency",   32'(res_lat),   32'd1);
    chk("miss_err",       32'(res_err),   32'd1);
    chk("miss_rdata",     res_rd,         32'h0);
    chk("miss_no_cs",     32'(res_cs),    32'd0);
    chk("miss_err_count", 32'(err_count), 32'd1);

    // 5: both masters held requesting, four transactions
    base = ack_total;
    ack_log.delete();
    @(negedge clk); #1;
    q0.push_back('{we: 1'b1, addr: 32'h0000_2310, wdata: 32'h0000_0111});
    q0.push_back('{we: 1'b0, addr: 32'h0000_2310, wdata: 32'h0});
    q1.push_back('{we: 1'b1, addr: 32'h0000_2320, wdata: 32'h0000_0222});
    q1.push_back('{we: 1'b0, addr: 32'h0000_2320, wdata: 32'h0});
    for (int i = 0; i < 200 && ack_total < base + 4; i++) begin
      @(negedge clk); #1;
    end
    chk("rr_ack_count", 32'(ack_total - base), 32'd4);
    if (ack_log.size() == 4) begin
      chk("rr_grant0", 32'(ack_log[0]), 32'd0);
      chk("rr_grant1", 32'(ack_log[1]), 32'd1);
      chk("rr_grant2", 32'(ack_log[2]), 32'd0);
      chk("rr_grant3", 32'(ack_log[3]), 32'd1);
    end
    chk("rr_m0_rdata",   m0_rdata,        32'h0000_0111);
    chk("rr_m1_rdata",   m1_rdata,        32'h0000_0222);
    chk("rr_double_ack", 32'(double_ack), 32'd0);

    // 6: reset during the WAIT of an m1 read, then a clean m1 read
    @(negedge clk); #1;
    q1.push_back('{we: 1'b0, addr: 32'h0000_2305, wdata: 32'h0});
    for (int i = 0; i < 20 && dbg_state != 2'd2; i++) begin
      @(negedge clk); #1;
    end
    chk("abort_in_wait", 32'(dbg_state), 32'd2);
    n1 = ack1_count;
    rst = 1'b1;
    m1_req = 1'b0;
    q1.delete();
    @(negedge clk); #1;
    chk("abort_state_idle", 32'(dbg_state), 32'd0);
    chk("abort_no_ack",     32'(m1_ack),    32'd0);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    #1 chk("abort_no_late_ack", 32'(ack1_count - n1), 32'd0);
    run_one(1'b1, 1'b0, 32'h0000_2370, 32'h0);
    chk("post_latency",   32'(res_lat),   32'd3);
    chk("post_err",       32'(res_err),   32'd0);
    chk("post_rdata",     res_rd,         32'hA5A5_0070);
    chk("post_err_count", 32'(err_count), 32'd0);

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #200000;
    n_err++;
    $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $fatal(1);
  end

endmodule
